// File: rtl/multicycle_main_fsm_pkg.sv
// rtl/multicycle_main_fsm_pkg.sv - shared control encodings for the multicycle RV32I control path
// Purpose: state encoding, opcode constants and datapath select encodings,
//          shared by the main FSM, the immediate-source decoder and the ALU decoder.
// Ports: none (package).
package multicycle_main_fsm_pkg;

  // 12 states used out of 16 encodings; the remaining four recover to S_FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_main_fsm_imm_src_decoder.sv
// rtl/multicycle_main_fsm_imm_src_decoder.sv - opcode to immediate-format select
// Purpose: purely combinational ImmSrc decode from the instruction opcode.
// Ports:
//   op       in  7  instr[6:0]
//   imm_src  out 2  I 00, S 01, B 10, J 11
module imm_src_decoder
  import multicycle_main_fsm_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  // Loads, I-type ALU and anything unrecognised fall back to the I format.
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - main control FSM for the multicycle RV32I datapath
// Purpose: sequences each instruction through fetch/decode/execute/memory/writeback
//          and drives datapath selects, write enables, ALUOp and ImmSrc.
// Ports:
//   clk, rst (sync, active-high)       in
//   op[6:0], zero, mem_ready           in
//   ALUOp, ALUSrcA, ALUSrcB, ResultSrc out 2 each
//   ImmSrc                             out 2 (combinational from op)
//   AdrSrc, IRWrite, PCWrite           out 1
//   RegWrite, MemWrite                 out 1
//   instr_done, illegal_instr          out 1
module multicycle_main_fsm
  import multicycle_main_fsm_pkg::*;
#(
  parameter int STATE_W         = 4,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       illegal_instr
);

  logic [STATE_W-1:0] state_q;
  state_t             state_d;
  logic               pc_update;
  logic               branch;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = S_FETCH;
    ALUOp         = ALUOP_ADD;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ResultSrc     = RES_ALUOUT;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        // IR load and PC+4 only on the cycle the fetch completes.
        IRWrite   = mem_ready;
        pc_update = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // OldPC + imm precomputes the branch target for BEQ.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_ILLEGAL;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ: begin
        // ALUOut still holds the target from DECODE; ALU compares rs1 - rs2.
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_SUB;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        // PC <- ALUOut (target from DECODE) while ALU forms OldPC+4 for rd.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ILLEGAL: begin
        illegal_instr = 1'b1;
        state_d       = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);

  imm_src_decoder u_imm_src_decoder (
    .op      (op),
    .imm_src (ImmSrc)
  );

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - directed self-checking bench for multicycle_main_fsm
module tb_multicycle_main_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  multicycle_main_fsm #(.STATE_W(4), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .ALUOp         (ALUOp),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ResultSrc     (ResultSrc),
    .ImmSrc        (ImmSrc),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Output bundle order: ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
  // AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr.
  function automatic logic [16:0] ev(input logic [1:0] aluop, srca, srcb, res, imm,
                                     input logic adr, irw, pcw, rw, mw, done, ill);
    return {aluop, srca, srcb, res, imm, adr, irw, pcw, rw, mw, done, ill};
  endfunction

  function automatic logic [16:0] x_fetch(input logic [1:0] imm, input logic mr);
    return ev(2'b00, 2'b00, 2'b10, 2'b10, imm, 1'b0, mr, mr, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_decode(input logic [1:0] imm);
    return ev(2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_memadr(input logic [1:0] imm);
    return ev(2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_memread(input logic [1:0] imm);
    return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_memwb(input logic [1:0] imm);
    return ev(2'b00, 2'b00, 2'b00, 2'b01, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] x_memwrite(input logic [1:0] imm, input logic mr);
    return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mr, 1'b0);
  endfunction
  function automatic logic [16:0] x_exr(input logic [1:0] imm);
    return ev(2'b10, 2'b10, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_exi(input logic [1:0] imm);
    return ev(2'b10, 2'b10, 2'b01, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_aluwb(input logic [1:0] imm);
    return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] x_beq(input logic [1:0] imm, input logic z);
    return ev(2'b01, 2'b10, 2'b00, 2'b00, imm, 1'b0, 1'b0, z, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [16:0] x_jal(input logic [1:0] imm);
    return ev(2'b00, 2'b01, 2'b10, 2'b00, imm, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [16:0] x_ill(input logic [1:0] imm);
    return ev(2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic add(input logic r, input logic [6:0] o, input logic z, input logic mr,
                     input logic [16:0] e);
    vec_t v;
    v.rst = r; v.op = o; v.zero = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle's inputs after the falling edge, compare mid-cycle,
  // and let the following rising edge advance the FSM.
  task automatic apply(input string name, input int idx, input logic r, input logic [6:0] o,
                       input logic z, input logic mr, input logic [16:0] e);
    logic [16:0] act;
    @(negedge clk);
    rst = r; op = o; zero = z; mem_ready = mr;
    #2;
    act = {ALUOp, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc,
           AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal_instr};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s[%0d] op=%b: got %05h want %05h", name, idx, o, act, e);
    end
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // add: 4 cycles
    add(0, RT, 0, 1, x_fetch(2'b00, 1));
    add(0, RT, 0, 1, x_decode(2'b00));
    add(0, RT, 0, 1, x_exr(2'b00));
    add(0, RT, 0, 1, x_aluwb(2'b00));
    // addi with a fetch stall; zero and mem_ready outside their states are ignored
    add(0, IT, 1, 0, x_fetch(2'b00, 0));
    add(0, IT, 1, 1, x_fetch(2'b00, 1));
    add(0, IT, 1, 1, x_decode(2'b00));
    add(0, IT, 1, 0, x_exi(2'b00));
    add(0, IT, 1, 0, x_aluwb(2'b00));
    // lw with two wait states in MEMREAD
    add(0, LW, 0, 1, x_fetch(2'b00, 1));
    add(0, LW, 0, 0, x_decode(2'b00));
    add(0, LW, 0, 0, x_memadr(2'b00));
    add(0, LW, 0, 0, x_memread(2'b00));
    add(0, LW, 0, 0, x_memread(2'b00));
    add(0, LW, 0, 1, x_memread(2'b00));
    add(0, LW, 0, 0, x_memwb(2'b00));
    // sw with one wait state
    add(0, SW, 0, 1, x_fetch(2'b01, 1));
    add(0, SW, 0, 1, x_decode(2'b01));
    add(0, SW, 0, 1, x_memadr(2'b01));
    add(0, SW, 0, 0, x_memwrite(2'b01, 0));
    add(0, SW, 0, 1, x_memwrite(2'b01, 1));
    // beq taken
    add(0, BQ, 1, 1, x_fetch(2'b10, 1));
    add(0, BQ, 1, 1, x_decode(2'b10));
    add(0, BQ, 1, 1, x_beq(2'b10, 1));
    // beq not taken
    add(0, BQ, 0, 1, x_fetch(2'b10, 1));
    add(0, BQ, 0, 1, x_decode(2'b10));
    add(0, BQ, 0, 1, x_beq(2'b10, 0));
    // jal
    add(0, JL, 0, 1, x_fetch(2'b11, 1));
    add(0, JL, 0, 1, x_decode(2'b11));
    add(0, JL, 0, 0, x_jal(2'b11));
    add(0, JL, 0, 0, x_aluwb(2'b11));
    // reset held 2 cycles starting in EXECUTER: no ALUWB afterwards
    add(0, RT, 0, 1, x_fetch(2'b00, 1));
    add(0, RT, 0, 1, x_decode(2'b00));
    add(1, RT, 0, 0, x_exr(2'b00));
    add(1, RT, 0, 0, x_fetch(2'b00, 0));
    add(0, RT, 0, 0, x_fetch(2'b00, 0));
    add(0, RT, 0, 1, x_fetch(2'b00, 1));
    add(0, RT, 0, 1, x_decode(2'b00));
    add(0, RT, 0, 1, x_exr(2'b00));
    add(0, RT, 0, 1, x_aluwb(2'b00));

    foreach (vecs[i])
      apply("vec", i, vecs[i].rst, vecs[i].op, vecs[i].zero, vecs[i].mr, vecs[i].exp);

    // Illegal opcode halts until reset, regardless of mem_ready/zero.
    apply("ill_fetch", 0, 0, BAD, 0, 1, x_fetch(2'b00, 1));
    apply("ill_decode", 0, 0, BAD, 0, 1, x_decode(2'b00));
    for (int k = 0; k < 10; k++)
      apply("ill_hold", k, 0, BAD, 1, 1, x_ill(2'b00));
    apply("ill_rst", 0, 1, BAD, 0, 0, x_ill(2'b00));
    apply("ill_cleared", 0, 0, RT, 0, 0, x_fetch(2'b00, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
